// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Multi-stage ripple adder/subtractor with a valid/ready handshake on both
//   sides. Operands are cut into STAGES slices of WIDTH/STAGES bits. Stage k
//   adds slice k (LSB slice first) using the carry registered by stage k-1.
//   Each stage registers: valid, carry, the finished low sum bits, the
//   operand bits not yet consumed, and the two operand sign bits used for ovf.
//   A stall (result presented but not taken) freezes the whole pipe.
//
// Parameters
//   WIDTH   operand/result width, 4..64
//   STAGES  pipeline depth; WIDTH must be a multiple of STAGES
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operation presented on a, b, cin, sub
//   in_ready   operation accepted this cycle (depends only on output side)
//   a, b       operands
//   cin        carry-in, add mode only
//   sub        0: a+b+cin   1: a-b
//   out_valid  result presented
//   out_ready  downstream accepts the result
//   sum        result
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SLICE = WIDTH / STAGES;

    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_addsub: WIDTH must be in 4..64");
    end
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_stages
        $error("pipelined_addsub: WIDTH must be an integer multiple of STAGES");
    end

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Subtraction is a + ~b + 1, so the inversion is done once at capture and
    // the forced carry replaces cin.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE = (k + 1) * SLICE;
        localparam int REM  = WIDTH - DONE;

        logic             vld;
        logic             cy;
        logic             a_msb;
        logic             b_msb;
        logic [DONE-1:0]  res;

        logic             vld_in;
        logic             cy_in;
        logic             a_msb_in;
        logic             b_msb_in;
        logic [SLICE-1:0] x;
        logic [SLICE-1:0] y;
        logic [SLICE:0]   part;
        logic [DONE-1:0]  res_in;

        if (k == 0) begin : g_head
            assign vld_in   = in_valid;
            assign cy_in    = c_eff;
            assign a_msb_in = a[WIDTH-1];
            assign b_msb_in = b_eff[WIDTH-1];
            assign x        = a[SLICE-1:0];
            assign y        = b_eff[SLICE-1:0];
            assign res_in   = part[SLICE-1:0];
        end else begin : g_body
            assign vld_in   = g_stage[k-1].vld;
            assign cy_in    = g_stage[k-1].cy;
            assign a_msb_in = g_stage[k-1].a_msb;
            assign b_msb_in = g_stage[k-1].b_msb;
            assign x        = g_stage[k-1].g_rem.rem_a[SLICE-1:0];
            assign y        = g_stage[k-1].g_rem.rem_b[SLICE-1:0];
            assign res_in   = {part[SLICE-1:0], g_stage[k-1].res};
        end

        assign part = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cy_in};

        // Data only moves with a valid op, so bubbles leave the last result
        // in place and never propagate undriven input values.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld   <= 1'b0;
                cy    <= 1'b0;
                a_msb <= 1'b0;
                b_msb <= 1'b0;
                res   <= '0;
            end else if (!stall) begin
                vld <= vld_in;
                if (vld_in) begin
                    cy    <= part[SLICE];
                    a_msb <= a_msb_in;
                    b_msb <= b_msb_in;
                    res   <= res_in;
                end
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] rem_a;
            logic [REM-1:0] rem_b;
            logic [REM-1:0] rem_a_in;
            logic [REM-1:0] rem_b_in;

            if (k == 0) begin : g_src
                assign rem_a_in = a[WIDTH-1:DONE];
                assign rem_b_in = b_eff[WIDTH-1:DONE];
            end else begin : g_src
                assign rem_a_in = g_stage[k-1].g_rem.rem_a[REM+SLICE-1:SLICE];
                assign rem_b_in = g_stage[k-1].g_rem.rem_b[REM+SLICE-1:SLICE];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rem_a <= '0;
                    rem_b <= '0;
                end else if (!stall && vld_in) begin
                    rem_a <= rem_a_in;
                    rem_b <= rem_b_in;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld;
    assign sum       = g_stage[STAGES-1].res;
    assign cout      = g_stage[STAGES-1].cy;
    assign ovf       = (g_stage[STAGES-1].a_msb == g_stage[STAGES-1].b_msb) &&
                       (sum[WIDTH-1] != g_stage[STAGES-1].a_msb);
endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits; legal range 4..64.
REQ-002 SHALL have parameter STAGES, default 4: number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES, and synthesis SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset, sampled on the rising clk edge.
REQ-005 SHALL have port in_valid, input, 1: an operation is presented on a, b, cin and sub.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the operation this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH each: the operands.
REQ-008 SHALL have port cin, input, 1: carry-in for add mode; ignored in subtract mode.
REQ-009 SHALL have port sub, input, 1: 0 selects a+b+cin; 1 selects a-b.
REQ-010 SHALL have port out_valid, output, 1: a result is presented.
REQ-011 SHALL have port out_ready, input, 1: the downstream block accepts the result.
REQ-012 SHALL have port sum, output, WIDTH: the result.
REQ-013 SHALL have port cout, output, 1: carry out of the MSB; in subtract mode, 1 means no borrow.
REQ-014 SHALL have port ovf, output, 1: signed two's-complement overflow.

Function
REQ-015 SHALL split operands into STAGES slices of SLICE = WIDTH/STAGES bits each; stage k ripple-adds slice k (LSB slice first) using the carry registered by stage k-1.
REQ-016 SHALL register, per stage, a valid bit, carry, the completed low sum bits, the remaining unprocessed operand bits and the sign bits needed for ovf.
REQ-017 SHALL, in subtract mode, add ~b with a forced carry-in of 1; b inversion SHALL happen at input capture.
REQ-018 SHALL define a transfer as in_valid && in_ready sampled high at a rising edge; the result of that transfer SHALL appear with out_valid=1 exactly STAGES cycles later when no stall occurs.
REQ-019 SHALL compute ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the b after mode inversion.
REQ-020 SHALL define stall = out_valid && !out_ready; while stall=1, every stage register SHALL hold its value.
REQ-021 SHALL drive in_ready = !stall; in_ready is combinational from out_valid and out_ready only, with no path from in_valid.
REQ-022 SHALL let a non-transfer cycle without a stall shift in a bubble (valid=0); bubbles SHALL NOT be collapsed.
REQ-023 SHALL keep sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain throughput of one operation per cycle while out_ready=1, with results in issue order and no drop or duplication.
REQ-025 SHALL treat sum, cout and ovf as don't-care when out_valid=0, but SHALL NOT produce X on them after reset.
REQ-026 SHALL, for STAGES=1, behave as a single registered ripple adder with latency 1.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, clear all stage valid bits, carries, data registers, sum, cout and ovf to 0.
REQ-028 SHALL drive out_valid=0 and in_ready=1 in the cycle after reset.
REQ-029 SHALL discard in-flight operations when reset is asserted mid-operation; none of them SHALL emerge afterwards.
REQ-030 SHALL ignore in_valid in any cycle where rst_n=0.

Verification (WIDTH=32, STAGES=4 unless stated)
REQ-031 Add: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 at cycle 0 -> cycle 4: out_valid=1, sum=0x00000000, cout=1, ovf=0.
REQ-032 Subtract: a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1; then a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-033 Throughput: 8 back-to-back transfers i, each a=i, b=i<<28, cin=1, with out_ready=1 -> 8 consecutive out_valid cycles from cycle 4, with sum=i+(i<<28)+1 in order.
REQ-034 Backpressure: out_ready=0 for 3 cycles while a result is presented -> in_ready=0, sum/cout/ovf held; then out_ready=1 -> stream resumes with no loss or duplication.
REQ-035 Mid-flight reset: issue 3 operations, assert rst_n=0 for 1 cycle at cycle 2 -> out_valid stays 0 for at least 4 subsequent cycles.
REQ-036 Random: 10k random a, b, cin, sub, in_valid and out_ready with WIDTH=16, STAGES=2 and WIDTH=32, STAGES=1 -> every result matches a reference model in order.
